// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames at a fixed bit period, with a two-flop input
// synchroniser, mid-bit sampling, and a valid/ack output with sticky errors.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t           state;
    state_t           state_next;
    logic             sync1;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             cnt_clr;
    logic             cnt_en;
    logic             start_ok;
    logic             shift_en;
    logic             done_ok;
    logic             done_bad;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control strobes for the datapath.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        start_ok   = 1'b0;
        shift_en   = 1'b0;
        done_ok    = 1'b0;
        done_bad   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                cnt_en = 1'b1;
                if (baud_cnt == HALF_TC) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                if (baud_cnt == FULL_TC) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                cnt_en = 1'b1;
                if (baud_cnt == FULL_TC) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        done_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        done_bad   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Synchroniser, baud counter, shift register, output byte and sticky flags.
    // The counter also restarts on every DATA tick, since DATA spans eight
    // bit periods without a state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync1 <= serial_in;
            rx_s  <= sync1;

            if (cnt_clr || (state_next != state)) begin
                baud_cnt <= '0;
            end else if (cnt_en) begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if (start_ok) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end

            if (done_ok) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rd_ack) begin
                rx_valid <= 1'b0;
            end

            if (done_ok && rx_valid && !rd_ack) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end

            if (done_bad) begin
                framing_err <= 1'b1;
            end else if (err_clr) begin
                framing_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a frame-level behavioural model.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       rd_ack;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       framing_err;
    logic       overrun_err;

    int total = 0;
    int bad   = 0;

    int cyc      = 0;
    int rise_cyc = 0;
    int rises    = 0;
    int busy_cnt = 0;
    bit prev_v   = 1'b0;

    // Frame-level model of what the receiver should present.
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_ferr;
    bit         m_oerr;

    // Snapshot of outputs taken just after the stop-bit sample point.
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ferr;
    logic       s_oerr;
    int         fall_cyc;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .rd_ack      (rd_ack),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && !prev_v) begin
            rise_cyc = cyc;
            rises    = rises + 1;
        end
        prev_v = (rx_valid === 1'b1);
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
    endtask

    // Outcome of a frame at its stop-bit sample; ack_mode 1 = rd_ack in that same cycle.
    task automatic model_frame(input logic [7:0] b, input bit stop, input int ack_mode);
        bit ackc;
        ackc = (ack_mode == 1);
        if (stop) begin
            if (m_valid && !ackc) m_oerr = 1'b1;
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
            if (ackc) m_valid = 1'b0;
        end
    endtask

    // Drives one 10-bit frame starting at a falling clock edge.
    // ack_mode: 0 none, 1 rd_ack coincident with the stop sample, 2 rd_ack just after.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_mode);
        logic [9:0] bits;
        bits     = {stop, b, 1'b0};
        fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            for (int j = 0; j < CPB; j++) begin
                if (i == 9) begin
                    rd_ack = ((ack_mode == 1) && (j == 10)) || ((ack_mode == 2) && (j == 12));
                    if (j == 11) begin
                        s_data  = rx_data;
                        s_valid = rx_valid;
                        s_ferr  = framing_err;
                        s_oerr  = overrun_err;
                    end
                end
                @(negedge clk);
            end
        end
        rd_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_oerr = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        serial_in = 1'b1;
        rd_ack    = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        total++;
        if ({rx_valid, busy, framing_err, overrun_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {rx_valid, busy, framing_err, overrun_err});
        end
        rst = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int r0;
        int lat;
        r0 = rises;
        send_frame(8'hA5, 1'b1, 0);
        model_frame(8'hA5, 1'b1, 0);
        lat = rise_cyc - fall_cyc;
        total++;
        if (s_data !== 8'hA5 || s_valid !== 1'b1) begin
            bad++; $display("FAIL basic_byte: got data=%h valid=%b want data=a5 valid=1", s_data, s_valid);
        end
        total++;
        if (rises - r0 != 1 || lat < 153 || lat > 156) begin
            bad++; $display("FAIL basic_latency: got %0d cycles (%0d rises) want 154+-1 (1 rise)", lat, rises - r0);
        end
        total++;
        if (busy !== 1'b0 || framing_err !== 1'b0 || overrun_err !== 1'b0) begin
            bad++; $display("FAIL basic_idle: got busy=%b ferr=%b oerr=%b want 0 0 0", busy, framing_err, overrun_err);
        end
        pulse_ack();
        total++;
        if (rx_valid !== m_valid) begin
            bad++; $display("FAIL basic_ack: got valid=%b want %b", rx_valid, m_valid);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rises;
        send_frame(8'h00, 1'b1, 2);
        model_frame(8'h00, 1'b1, 2);
        total++;
        if (s_data !== m_data || s_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_first: got data=%h valid=%b want data=%h valid=1", s_data, s_valid, m_data);
        end
        m_valid = 1'b0;
        send_frame(8'hFF, 1'b1, 2);
        model_frame(8'hFF, 1'b1, 2);
        total++;
        if (s_data !== m_data || s_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_second: got data=%h valid=%b want data=%h valid=1", s_data, s_valid, m_data);
        end
        m_valid = 1'b0;
        total++;
        if (rises - r0 != 2 || framing_err !== 1'b0 || overrun_err !== 1'b0 || rx_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_summary: got rises=%0d ferr=%b oerr=%b valid=%b want 2 0 0 0",
                            rises - r0, framing_err, overrun_err, rx_valid);
        end
    endtask

    task automatic test_glitch();
        int b0;
        int r0;
        b0 = busy_cnt;
        r0 = rises;
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        repeat (14) @(negedge clk);
        total++;
        if (busy_cnt - b0 < 6 || busy_cnt - b0 > 10 || busy !== 1'b0) begin
            bad++; $display("FAIL glitch_busy: got busy_cycles=%0d busy=%b want 6..10 then 0", busy_cnt - b0, busy);
        end
        total++;
        if (rises != r0 || rx_valid !== 1'b0 || framing_err !== 1'b0 || overrun_err !== 1'b0) begin
            bad++; $display("FAIL glitch_quiet: got valid=%b ferr=%b oerr=%b want 0 0 0", rx_valid, framing_err, overrun_err);
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 0);
        model_frame(8'h3C, 1'b0, 0);
        total++;
        if (s_ferr !== 1'b1 || s_valid !== 1'b0 || s_data !== m_data) begin
            bad++; $display("FAIL framing_set: got ferr=%b valid=%b data=%h want 1 0 %h", s_ferr, s_valid, s_data, m_data);
        end
        repeat (24) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL framing_wait: got busy=%b want 1 while line low", busy);
        end
        serial_in = 1'b1;
        repeat (16) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL framing_release: got busy=%b want 0", busy);
        end
        send_frame(8'h81, 1'b1, 0);
        model_frame(8'h81, 1'b1, 0);
        total++;
        if (s_data !== 8'h81 || s_valid !== 1'b1 || s_ferr !== 1'b1) begin
            bad++; $display("FAIL framing_next: got data=%h valid=%b ferr=%b want 81 1 1", s_data, s_valid, s_ferr);
        end
        pulse_clr();
        total++;
        if (framing_err !== m_ferr || rx_valid !== m_valid) begin
            bad++; $display("FAIL framing_clr: got ferr=%b valid=%b want %b %b", framing_err, rx_valid, m_ferr, m_valid);
        end
        pulse_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 0);
        model_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        model_frame(8'h22, 1'b1, 0);
        total++;
        if (s_oerr !== m_oerr || s_data !== 8'h22 || s_valid !== 1'b1) begin
            bad++; $display("FAIL overrun_set: got oerr=%b data=%h valid=%b want %b 22 1", s_oerr, s_data, s_valid, m_oerr);
        end
        pulse_clr();
        total++;
        if (overrun_err !== 1'b0) begin
            bad++; $display("FAIL overrun_clr: got oerr=%b want 0", overrun_err);
        end
        pulse_ack();
        send_frame(8'h11, 1'b1, 0);
        model_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 1);
        model_frame(8'h22, 1'b1, 1);
        total++;
        if (s_oerr !== m_oerr || s_data !== 8'h22 || s_valid !== 1'b1) begin
            bad++; $display("FAIL overrun_ack_same: got oerr=%b data=%h valid=%b want %b 22 1", s_oerr, s_data, s_valid, m_oerr);
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        int r0;
        bits = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            serial_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rst       = 1'b0;
        serial_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        total++;
        if ({rx_data, rx_valid, busy, framing_err, overrun_err} !== 12'h000) begin
            bad++; $display("FAIL midreset_outputs: got data=%h valid=%b busy=%b ferr=%b oerr=%b want all 0",
                            rx_data, rx_valid, busy, framing_err, overrun_err);
        end
        r0 = rises;
        repeat (200) @(negedge clk);
        total++;
        if (rises != r0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_abandon: got rises=%0d valid=%b busy=%b want 0 0 0", rises - r0, rx_valid, busy);
        end
        send_frame(8'h5A, 1'b1, 0);
        model_frame(8'h5A, 1'b1, 0);
        total++;
        if (s_data !== 8'h5A || s_valid !== 1'b1 || s_ferr !== 1'b0 || s_oerr !== 1'b0) begin
            bad++; $display("FAIL midreset_next: got data=%h valid=%b ferr=%b oerr=%b want 5a 1 0 0", s_data, s_valid, s_ferr, s_oerr);
        end
        pulse_ack();
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         stop;
        int         am;
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            am   = int'($urandom_range(0, 2));
            send_frame(b, stop, am);
            model_frame(b, stop, am);
            total++;
            if (s_data !== m_data || s_valid !== m_valid || s_ferr !== m_ferr || s_oerr !== m_oerr) begin
                bad++; $display("FAIL random_frame%0d: got data=%h v=%b fe=%b oe=%b want data=%h v=%b fe=%b oe=%b",
                                n, s_data, s_valid, s_ferr, s_oerr, m_data, m_valid, m_ferr, m_oerr);
            end
            if (am == 2) m_valid = 1'b0;
            if (!stop) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                serial_in = 1'b1;
                repeat (CPB) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 3) == 0) pulse_clr();
            total++;
            if (rx_valid !== m_valid || framing_err !== m_ferr || overrun_err !== m_oerr) begin
                bad++; $display("FAIL random_after%0d: got v=%b fe=%b oe=%b want v=%b fe=%b oe=%b",
                                n, rx_valid, framing_err, overrun_err, m_valid, m_ferr, m_oerr);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
